ft232h_fifo_ctrl: RTL and testbench
===================================

Name: ft232h_fifo_ctrl

Overview:
FPGA-side controller for the FT232H in 245 synchronous-FIFO mode. It runs on the FT232H clkout domain and drives wr/rd/oe/siwu. It splits the bidirectional adbus into in, out and output-enable, and arbitrates bus direction between reads and writes. Host-to-FPGA bytes go out on a valid/ready rx stream through a small FIFO. FPGA-to-host bytes come in on a valid/ready tx stream through a one-word holding register.

Parameters:
RX_DEPTH, 4, rx FIFO entries; power of 2, minimum 2
MAX_BURST, 64, maximum words per READ or WRITE burst before the other direction is offered the bus
FLUSH_IDLE, 16, idle cycles after the last write before a siwu flush (optional feature only)

Ports:
clkout  in  1  FT232H 60 MHz clock, the only clock
rst  in  1  asynchronous reset, active-high
adbus_i  in  8  adbus input path
adbus_o  out  8  adbus output path
adbus_oe  out  1  1 = FPGA drives adbus
txe  in  1  active-low; FT232H can accept a write
rxf  in  1  active-low; FT232H has read data
wr  out  1  active-low write strobe
rd  out  1  active-low read strobe
oe  out  1  active-low FT232H output enable
siwu  out  1  active-low send-immediate
rx_data  out  8  received byte
rx_valid  out  1  rx FIFO not empty
rx_ready  in  1  consumer accepts rx_data
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty

Behaviour:
- Reset (asynchronous, immediate, also mid-burst):
  - state = IDLE, rx FIFO empty, holding register empty, burst counter = 0.
  - wr = rd = oe = siwu = 1; adbus_oe = 0; rx_valid = 0; tx_ready = 1; adbus_o = 0.
  - A word that was in flight is discarded.
- States: IDLE, RD_TURN, READ, WRITE. All registered on rising clkout.
- IDLE:
  - If rxf==0 and rx FIFO count < RX_DEPTH: go to RD_TURN.
  - Else if txe==0 and the holding register is full: go to WRITE.
  - When both qualify, read wins, except immediately after a READ burst that ended on MAX_BURST; then write wins once.
- RD_TURN: oe = 0 for one cycle, rd = 1; then go to READ. This is the bus turnaround.
- READ:
  - oe = 0.
  - rd = ~(rxf==0 && count<RX_DEPTH); combinational from registered count and rxf.
  - A byte is captured into the FIFO at every rising edge where rd==0 and rxf==0.
  - Exit to IDLE the cycle after rxf==1, FIFO full, or MAX_BURST captures. oe returns to 1 in IDLE.
- WRITE:
  - adbus_oe = 1; adbus_o = holding register.
  - wr = ~(txe==0 && hold_valid); combinational.
  - A word is transferred at every rising edge where wr==0. The holding register empties at that edge.
  - Exit to IDLE when txe==1, the holding register is empty and tx_valid==0, or after MAX_BURST transfers.
- Holding register: tx_ready = ~hold_valid, or 1 when the register transfers in the same cycle. It loads on tx_valid && tx_ready, including a same-cycle transfer-and-reload, so back-to-back writes sustain 1 byte/clock.
- rx FIFO:
  - rx_data comes from the head, first-word fall-through. rx_valid = count!=0.
  - Pop on rx_valid && rx_ready. Simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo RX_DEPTH. Never push when full; rd is held high.
- Direction change always passes through IDLE, one cycle with oe=1 and adbus_oe=0. adbus_oe and oe==0 are never asserted together.
- Burst counter resets on entry to READ or WRITE and saturates at MAX_BURST.

Optional Feature:
SIWU_FLUSH_EN
- Defined: an idle counter clears on each write transfer and counts cycles with no transfer while the holding register is empty. When it reaches FLUSH_IDLE after at least one write since the last flush, siwu = 0 for exactly one cycle, in IDLE or WRITE only, then the counter re-arms. Reset clears the counter.
- Undefined: siwu is held at 1.

Test Plan:
1. Write burst: txe=0, push 0xAA,0xBB,0xCC,0xDD back-to-back -> wr low 4 consecutive cycles, adbus_o=AA,BB,CC,DD on successive edges, adbus_oe=1, then IDLE.
2. Write stall: raise txe after 2 bytes -> wr=1 in the same cycle, byte 0xCC held, resumes on txe=0, no loss or duplication.
3. Read: rxf=0 supplying 0x11..0x14, rx_ready=1 -> oe low 1 cycle before rd, rx stream delivers 11,12,13,14 in order.
4. Backpressure: rx_ready=0, 6 bytes available, RX_DEPTH=4 -> rd rises after 4 captures, exit to IDLE, remaining 2 bytes read after draining.
5. Contention: rxf=0 and txe=0 with pending tx, MAX_BURST=4 -> 4 reads, 1 IDLE cycle (oe=1, adbus_oe=0), write burst, never both drivers.
6. Reset mid-READ: assert rst -> rd=oe=1 immediately, rx_valid=0, state IDLE; SIWU_FLUSH_EN build: single write then 16 idle cycles -> one-cycle siwu=0.

Source files
------------

// File: rtl/ft232h_fifo_ctrl.sv
// FT232H 245 synchronous-FIFO controller: bus direction arbitration, rx FIFO, tx holding register.
// Optional macro SIWU_FLUSH_EN: pulse siwu low after FLUSH_IDLE idle cycles following writes.
module ft232h_fifo_ctrl #(
    parameter int RX_DEPTH   = 4,
    parameter int MAX_BURST  = 64,
    parameter int FLUSH_IDLE = 16
) (
    input  logic       clkout,
    input  logic       rst,
    input  logic [7:0] adbus_i,
    output logic [7:0] adbus_o,
    output logic       adbus_oe,
    input  logic       txe,
    input  logic       rxf,
    output logic       wr,
    output logic       rd,
    output logic       oe,
    output logic       siwu,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [AW:0]   FULL_CNT  = RX_DEPTH[AW:0];
    localparam logic [BW-1:0] BURST_MAX = MAX_BURST[BW-1:0];

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_TURN = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [BW-1:0] burst;
    logic          write_prio;
    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          hold_valid;
    logic [7:0]    hold_data;
    logic          rd_req;
    logic          wr_req;
    logic          burst_left;
    logic          capture;
    logic          xfer;
    logic          pop;
    logic          load;

    assign rd_req     = !rxf && (count != FULL_CNT);
    assign wr_req     = !txe && hold_valid;
    assign burst_left = (burst != BURST_MAX);
    assign capture    = (state == READ) && rd_req && burst_left;
    assign xfer       = (state == WRITE) && wr_req && burst_left;

    assign rd       = ~capture;
    assign wr       = ~xfer;
    assign oe       = ~((state == RD_TURN) || (state == READ));
    assign adbus_oe = (state == WRITE);
    assign adbus_o  = adbus_oe ? hold_data : 8'h00;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_req && (write_prio || !rd_req)) begin
                    state_nxt = WRITE;
                end else if (rd_req) begin
                    state_nxt = RD_TURN;
                end
            end
            RD_TURN: state_nxt = READ;
            // A cycle without a capture (empty, full or burst exhausted) ends the read burst
            READ: begin
                if (!capture) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (txe || (!hold_valid && !tx_valid) || !burst_left) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            burst      <= '0;
            write_prio <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) || (state == RD_TURN)) begin
                burst <= '0;
            end else if (capture || xfer) begin
                burst <= burst + 1'b1;
            end
            // A read burst cut short by MAX_BURST hands the next contended slot to writes
            if ((state == READ) && (state_nxt == IDLE)) begin
                write_prio <= !burst_left;
            end else if ((state == IDLE) && (state_nxt != IDLE)) begin
                write_prio <= 1'b0;
            end
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = fifo_mem[rptr];
    assign pop      = rx_valid && rx_ready;

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (capture) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkout) begin
        if (capture) begin
            fifo_mem[wptr] <= adbus_i;
        end
    end

    // Ready while the word goes out this cycle, so a reload keeps 1 byte/clock
    assign tx_ready = !hold_valid || xfer;
    assign load     = tx_valid && tx_ready;

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid <= 1'b1;
        end else if (xfer) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clkout) begin
        if (load) begin
            hold_data <= tx_data;
        end
    end

`ifdef SIWU_FLUSH_EN
    localparam int IW = $clog2(FLUSH_IDLE + 1);
    localparam logic [IW-1:0] IDLE_MAX = FLUSH_IDLE[IW-1:0];

    logic [IW-1:0] idle_cnt;
    logic          armed;
    logic          flush;

    assign flush = armed && (idle_cnt == IDLE_MAX) && ((state == IDLE) || (state == WRITE));
    assign siwu  = ~flush;

    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            armed    <= 1'b0;
        end else if (xfer) begin
            idle_cnt <= '0;
            armed    <= 1'b1;
        end else if (flush) begin
            idle_cnt <= '0;
            armed    <= 1'b0;
        end else if (!hold_valid && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Flush disabled: siwu stays inactive whatever FLUSH_IDLE is set to
    assign siwu = 1'b1 | (FLUSH_IDLE == 0);
`endif

endmodule

// File: tb/tb_ft232h_fifo_ctrl.sv
// Bench for ft232h_fifo_ctrl: FT232H chip model with byte queues, directed scenarios and random traffic.
module tb_ft232h_fifo_ctrl;
    localparam int RX_DEPTH   = 4;
    localparam int MAX_BURST  = 4;
    localparam int FLUSH_IDLE = 16;

    logic       clkout   = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] adbus_i  = 8'h00;
    logic [7:0] adbus_o;
    logic       adbus_oe;
    logic       txe      = 1'b1;
    logic       rxf      = 1'b1;
    logic       wr;
    logic       rd;
    logic       oe;
    logic       siwu;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;

    int total = 0;
    int fails = 0;

    byte unsigned h2f[$];      // bytes the host still has to hand to the FPGA
    byte unsigned exp_rx[$];   // captured by the FPGA, awaiting the rx stream
    byte unsigned tx_src[$];   // bytes the user logic wants to send
    byte unsigned exp_host[$]; // accepted by the FPGA, awaiting a wr strobe

    logic rxf_block = 1'b0;
    logic txe_block = 1'b1;
    logic tx_gate   = 1'b1;
    logic prev_oe   = 1'b1;
    int   wr_count  = 0;
    int   rd_count  = 0;
    int   rx_pops   = 0;
    int   conflicts = 0;
    int   bad_turn  = 0;
    int   siwu_lows = 0;

    ft232h_fifo_ctrl #(
        .RX_DEPTH(RX_DEPTH),
        .MAX_BURST(MAX_BURST),
        .FLUSH_IDLE(FLUSH_IDLE)
    ) dut (
        .clkout(clkout),
        .rst(rst),
        .adbus_i(adbus_i),
        .adbus_o(adbus_o),
        .adbus_oe(adbus_oe),
        .txe(txe),
        .rxf(rxf),
        .wr(wr),
        .rd(rd),
        .oe(oe),
        .siwu(siwu),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clkout = ~clkout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic apply();
        rxf      = rxf_block || (h2f.size() == 0);
        adbus_i  = (h2f.size() != 0) ? h2f[0] : 8'h00;
        txe      = txe_block;
        tx_valid = tx_gate && (tx_src.size() != 0);
        tx_data  = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clkout);
            apply();
            #1;
        end
    endtask

    // Chip side and stream scoreboards, sampling pre-edge values
    always @(posedge clkout) begin
        if (adbus_oe && !oe) conflicts++;
        if (!wr && !adbus_oe) conflicts++;
        if (!rd && prev_oe) bad_turn++;
        if (!siwu) begin
            siwu_lows++;
            if (!oe) conflicts++;
        end
        prev_oe = oe;
        if (!rst) begin
            if (!rd && !rxf) begin
                exp_rx.push_back(h2f.pop_front());
                rd_count++;
            end
            if (rx_valid && rx_ready) begin
                rx_pops++;
                check("rx_has_expect", 32'(exp_rx.size() > 0), 32'd1);
                if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (tx_valid && tx_ready) begin
                exp_host.push_back(tx_data);
                void'(tx_src.pop_front());
            end
            if (!wr) begin
                wr_count++;
                check("wr_has_expect", 32'(exp_host.size() > 0), 32'd1);
                if (exp_host.size() > 0) check("adbus_o", 32'(adbus_o), 32'(exp_host.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int base_pop;
        int run;
        int max_run;
        int first_wr;
        int reads_before;
        int gap_idle;
        int remaining;

        cyc(2);
        check("rst_rd", 32'(rd), 32'd1);
        check("rst_wr", 32'(wr), 32'd1);
        check("rst_oe", 32'(oe), 32'd1);
        check("rst_siwu", 32'(siwu), 32'd1);
        check("rst_adbus_oe", 32'(adbus_oe), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_adbus_o", 32'(adbus_o), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Back-to-back write burst
        base = wr_count;
        run = 0;
        max_run = 0;
        tx_src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        txe_block = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (!wr) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
        check("t1_wr_run", max_run, 4);
        check("t1_wr_total", wr_count - base, 4);
        check("t1_back_idle", 32'(adbus_oe), 32'd0);
        check("t1_drained", exp_host.size(), 0);

        // Write stall on txe
        base = wr_count;
        tx_src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 40 && wr_count < base + 2; i++) cyc(1);
        check("t2_two_sent", wr_count - base, 2);
        txe_block = 1'b1;
        apply();
        #1;
        check("t2_wr_drops", 32'(wr), 32'd1);
        check("t2_hold_cc", 32'(adbus_o), 32'hCC);
        check("t2_tx_ready_low", 32'(tx_ready), 32'd0);
        cyc(5);
        check("t2_stalled", wr_count - base, 2);
        check("t2_released_bus", 32'(adbus_oe), 32'd0);
        txe_block = 1'b0;
        for (int i = 0; i < 40 && wr_count < base + 4; i++) cyc(1);
        cyc(3);
        check("t2_all_sent", wr_count - base, 4);
        check("t2_no_leftover", exp_host.size() + tx_src.size(), 0);
        txe_block = 1'b1;

        // Read with turnaround
        base = rd_count;
        base_pop = rx_pops;
        rx_ready = 1'b1;
        h2f = '{8'h11, 8'h12, 8'h13, 8'h14};
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!oe) break;
        end
        check("t3_turn_seen", 32'(oe), 32'd0);
        check("t3_rd_high_in_turn", 32'(rd), 32'd1);
        cyc(1);
        check("t3_rd_after_turn", 32'(rd), 32'd0);
        cyc(20);
        check("t3_reads", rd_count - base, 4);
        check("t3_delivered", rx_pops - base_pop, 4);
        check("t3_oe_back", 32'(oe), 32'd1);

        // Backpressure fills the rx FIFO
        base = rd_count;
        base_pop = rx_pops;
        rx_ready = 1'b0;
        h2f = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        cyc(30);
        check("t4_captures", rd_count - base, RX_DEPTH);
        check("t4_left_in_host", h2f.size(), 2);
        check("t4_rx_valid", 32'(rx_valid), 32'd1);
        check("t4_rd_held", 32'(rd), 32'd1);
        check("t4_idle", 32'(oe), 32'd1);
        rx_ready = 1'b1;
        cyc(40);
        check("t4_all_read", rd_count - base, 6);
        check("t4_all_delivered", rx_pops - base_pop, 6);
        check("t4_rx_empty", exp_rx.size(), 0);

        // Contention: both sides pending
        rxf_block = 1'b1;
        tx_src = '{8'h51, 8'h52, 8'h53};
        h2f = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        cyc(4);
        first_wr = -1;
        reads_before = 0;
        gap_idle = 0;
        rxf_block = 1'b0;
        txe_block = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (first_wr < 0) begin
                if (!wr) first_wr = i;
                else if (!rd) begin
                    reads_before++;
                    gap_idle = 0;
                end else if (oe && !adbus_oe && reads_before > 0) gap_idle++;
            end
        end
        check("t5_write_happened", 32'(first_wr >= 0), 32'd1);
        check("t5_read_burst", reads_before, MAX_BURST);
        check("t5_idle_gap", 32'(gap_idle > 0), 32'd1);
        check("t5_tx_done", exp_host.size() + tx_src.size(), 0);
        check("t5_rx_done", exp_rx.size() + h2f.size(), 0);
        check("t5_no_conflict", conflicts, 0);
        txe_block = 1'b1;

        // Asynchronous reset in the middle of a read burst
        rx_ready = 1'b0;
        h2f = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78};
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (!rd) break;
        end
        check("t6_in_read", 32'(rd), 32'd0);
        #2;
        rst = 1'b1;
        exp_rx.delete();
        #1;
        check("t6_rd", 32'(rd), 32'd1);
        check("t6_oe", 32'(oe), 32'd1);
        check("t6_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
        check("t6_adbus_oe", 32'(adbus_oe), 32'd0);
        cyc(2);
        rst = 1'b0;
        remaining = h2f.size();
        base_pop = rx_pops;
        rx_ready = 1'b1;
        cyc(40);
        check("t6_resume", rx_pops - base_pop, remaining);
        check("t6_host_empty", h2f.size(), 0);

        // Random traffic in both directions
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && h2f.size() < 16) h2f.push_back(8'($urandom));
            if ($urandom_range(0, 2) == 0 && tx_src.size() < 16) tx_src.push_back(8'($urandom));
            rx_ready  = ($urandom_range(0, 3) != 0);
            rxf_block = ($urandom_range(0, 5) == 0);
            txe_block = ($urandom_range(0, 5) == 0);
            tx_gate   = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        rx_ready = 1'b1;
        rxf_block = 1'b0;
        txe_block = 1'b0;
        tx_gate = 1'b1;
        cyc(200);
        check("rand_rx_drained", exp_rx.size() + h2f.size(), 0);
        check("rand_tx_drained", exp_host.size() + tx_src.size(), 0);
        check("bus_conflicts", conflicts, 0);
        check("turnaround", bad_turn, 0);

`ifdef SIWU_FLUSH_EN
        base = siwu_lows;
        tx_src.push_back(8'h5A);
        cyc(50);
        check("siwu_one_pulse", siwu_lows - base, 1);
        check("siwu_write_sent", exp_host.size() + tx_src.size(), 0);
`else
        check("siwu_parked", siwu_lows, 0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
